vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Schedules the single-port VRAM between two requesters: the display fetch engine (read-only, latency-sensitive) and the MPU port (read/write, byte-enabled).
- Owns all VRAM control pins and the data-bus drive enable; the top level builds the tristate from vram_oe.
- Display has priority; a bounded-starvation counter guarantees MPU progress.
- Inserts a bus-turnaround slot between a read and a following write.

Parameters:
ADDR_WIDTH, 16, VRAM/request address width
DATA_WIDTH, 16, VRAM word width
MPU_MAX_WAIT, 4, max consecutive display grants while mpu_req pending before MPU is forced (1..15)

Ports:
clk  in  1  system clock, all state on rising edge
_reset  in  1  asynchronous active-low reset
disp_req  in  1  display read request, held until disp_ack
disp_addr  in  ADDR_WIDTH  display word address, stable while disp_req high
disp_ack  out  1  one-cycle pulse: display access on VRAM this cycle
disp_data  out  DATA_WIDTH  display read data
disp_valid  out  1  one-cycle pulse: disp_data valid
mpu_req  in  1  MPU request, held until mpu_ack
mpu_wr  in  1  1=write, 0=read; stable while mpu_req high
_mpu_be  in  2  active-low byte enables, [1]=high byte
mpu_addr  in  ADDR_WIDTH  MPU word address
mpu_wdata  in  DATA_WIDTH  MPU write data
mpu_ack  out  1  one-cycle pulse: MPU access on VRAM this cycle
mpu_rdata  out  DATA_WIDTH  MPU read data
mpu_rvalid  out  1  one-cycle pulse: mpu_rdata valid (reads only)
_vram_en  out  1  VRAM chip enable, active low
_vram_rd  out  1  VRAM output enable, active low
_vram_wr  out  1  VRAM write strobe, active low
_vram_be  out  2  VRAM byte enables, active low
vram_addr  out  ADDR_WIDTH  VRAM address
vram_dout  out  DATA_WIDTH  write data to pad
vram_oe  out  1  1=drive vram_dout onto the VRAM bus
vram_din  in  DATA_WIDTH  read data from pad

Behaviour:
- Reset: state IDLE; _vram_en/_vram_rd/_vram_wr=1; _vram_be=2'b11; vram_addr/vram_dout=0; vram_oe=0; disp_ack/disp_valid/mpu_ack/mpu_rvalid=0; disp_data/mpu_rdata=0; starvation counter=0.
- All VRAM outputs and acks are registered. One access per cycle.
- FSM states: IDLE, RD, WR, TURN. Each edge selects the next state from the requests.
- RD state: _vram_en=0, _vram_rd=0, _vram_wr=1, vram_oe=0.
  - Display read: _vram_be=00.
  - MPU read: _vram_be=_mpu_be.
- WR state: _vram_en=0, _vram_wr=0, _vram_rd=1, vram_oe=1, _vram_be=_mpu_be, vram_dout=mpu_wdata.
- TURN state: all strobes high, vram_oe=0, no ack.
- Arbitration at each edge, from current requests:
  - If the counter has reached MPU_MAX_WAIT and mpu_req=1, MPU wins. Otherwise disp_req wins over mpu_req.
  - An MPU write granted while the current state is RD goes to TURN, then WR; mpu_ack asserts in the WR cycle.
  - During TURN the pending MPU write is committed; a display request waits.
  - A read following WR needs no turnaround: vram_oe drops on the same edge that enters RD.
- Starvation counter:
  - Increments (saturating at MPU_MAX_WAIT) on each display grant while mpu_req=1.
  - Clears on any MPU grant or when mpu_req=0.
- Latency:
  - Request sampled high at edge N produces ack high during cycle N..N+1 (the VRAM access cycle).
  - vram_din is captured at the edge ending the access cycle.
  - disp_valid/mpu_rvalid is high for exactly one cycle after that edge, with data stable in that cycle.
  - Back-to-back requests give one access per cycle (full throughput).
- Handshake:
  - The requester keeps req and its fields stable until the cycle ack is high.
  - Keeping req high after ack means a new request, sampled at the edge ending the ack cycle.
  - Dropping req before ack is illegal; behaviour is undefined and is flagged by a simulation assertion.
- _mpu_be=11 on a write: the cycle still executes and acks, with no byte written. On a read it returns the full word regardless.
- Idle (no requests): IDLE, all strobes inactive, vram_oe=0.
- Reset mid-access: outputs return to reset values immediately (async); pending read data is discarded and no valid is issued.

Test Plan:
- Single MPU write at 0x1234, data 0xBEEF, _mpu_be=00 -> one cycle with _vram_wr=0, vram_oe=1, vram_addr=0x1234; mpu_ack 1 cycle; no mpu_rvalid.
- MPU read of 0x0010 with vram_din=0xA5A5 -> mpu_ack then mpu_rvalid next cycle with mpu_rdata=0xA5A5; _vram_be follows _mpu_be=10.
- Display reads 0x0000..0x0007 back-to-back -> 8 consecutive disp_ack cycles; disp_valid cycles carry the respective vram_din values with 1-cycle offset.
- Continuous disp_req plus MPU read pending, MPU_MAX_WAIT=4 -> exactly 4 display grants, 1 MPU grant, repeat.
- Display read immediately followed by MPU write -> RD, TURN (all strobes high, vram_oe=0), WR; mpu_ack only in WR cycle.
- Assert _reset=0 during an MPU read access cycle -> strobes high asynchronously; no mpu_rvalid after release; first post-reset request is served normally.

Source files
------------

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vram_arbiter
//  Purpose  : Single-port VRAM scheduler between the display fetch engine
//             (read-only, priority) and the MPU port (read/write, byte
//             enables). Owns every VRAM control pin, inserts a turnaround
//             slot between a read and a following write, and bounds MPU
//             starvation with a saturating wait counter.
//  Revision : 1.0  initial release
// ============================================================================
module vram_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int MPU_MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  _reset,
    input  logic                  disp_req,
    input  logic [ADDR_WIDTH-1:0] disp_addr,
    output logic                  disp_ack,
    output logic [DATA_WIDTH-1:0] disp_data,
    output logic                  disp_valid,
    input  logic                  mpu_req,
    input  logic                  mpu_wr,
    input  logic [1:0]            _mpu_be,
    input  logic [ADDR_WIDTH-1:0] mpu_addr,
    input  logic [DATA_WIDTH-1:0] mpu_wdata,
    output logic                  mpu_ack,
    output logic [DATA_WIDTH-1:0] mpu_rdata,
    output logic                  mpu_rvalid,
    output logic                  _vram_en,
    output logic                  _vram_rd,
    output logic                  _vram_wr,
    output logic [1:0]            _vram_be,
    output logic [ADDR_WIDTH-1:0] vram_addr,
    output logic [DATA_WIDTH-1:0] vram_dout,
    output logic                  vram_oe,
    input  logic [DATA_WIDTH-1:0] vram_din
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        TURN = 2'd3
    } state_t;

    // Counter is 4 bits wide: the wait limit is at most 15.
    localparam logic [3:0] MAX_WAIT_C = 4'(MPU_MAX_WAIT);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    en_q, en_d, rd_q, rd_d, wr_q, wr_d, oe_q, oe_d;
    logic [1:0]              be_q, be_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic                    disp_ack_q, disp_ack_d, mpu_ack_q, mpu_ack_d;
    logic                    disp_valid_q, disp_valid_d, mpu_rvalid_q, mpu_rvalid_d;
    logic [DATA_WIDTH-1:0]   disp_data_q, disp_data_d, mpu_rdata_q, mpu_rdata_d;
    logic                    mpu_force;

    // MPU is forced once the display has won MPU_MAX_WAIT times in a row.
    assign mpu_force = mpu_req && (cnt_q == MAX_WAIT_C);

    // Arbitration, next state, next pin values and read-data capture.
    always_comb begin
        state_d    = IDLE;
        cnt_d      = '0;
        en_d       = 1'b1;
        rd_d       = 1'b1;
        wr_d       = 1'b1;
        oe_d       = 1'b0;
        be_d       = 2'b11;
        addr_d     = addr_q;
        dout_d     = dout_q;
        disp_ack_d = 1'b0;
        mpu_ack_d  = 1'b0;
        // The access that ends at this edge yields read data now.
        disp_valid_d = disp_ack_q;
        mpu_rvalid_d = mpu_ack_q && (state_q == RD);
        disp_data_d  = disp_ack_q ? vram_din : disp_data_q;
        mpu_rdata_d  = (mpu_ack_q && (state_q == RD)) ? vram_din : mpu_rdata_q;

        if (state_q == TURN) begin
            // The write was granted at the previous edge; commit it now.
            state_d   = WR;
            en_d      = 1'b0;
            wr_d      = 1'b0;
            oe_d      = 1'b1;
            be_d      = _mpu_be;
            addr_d    = mpu_addr;
            dout_d    = mpu_wdata;
            mpu_ack_d = 1'b1;
        end else if (mpu_req && (mpu_force || !disp_req)) begin
            if (!mpu_wr) begin
                state_d   = RD;
                en_d      = 1'b0;
                rd_d      = 1'b0;
                be_d      = _mpu_be;
                addr_d    = mpu_addr;
                mpu_ack_d = 1'b1;
            end else if (state_q == RD) begin
                // Bus still carries read data: idle one slot first.
                state_d = TURN;
            end else begin
                state_d   = WR;
                en_d      = 1'b0;
                wr_d      = 1'b0;
                oe_d      = 1'b1;
                be_d      = _mpu_be;
                addr_d    = mpu_addr;
                dout_d    = mpu_wdata;
                mpu_ack_d = 1'b1;
            end
        end else if (disp_req) begin
            state_d    = RD;
            en_d       = 1'b0;
            rd_d       = 1'b0;
            be_d       = 2'b00;
            addr_d     = disp_addr;
            disp_ack_d = 1'b1;
            if (mpu_req) begin
                cnt_d = (cnt_q == MAX_WAIT_C) ? cnt_q : cnt_q + 4'd1;
            end
        end
    end

    // State, pin and handshake registers; reset returns pins to idle at once.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            en_q         <= 1'b1;
            rd_q         <= 1'b1;
            wr_q         <= 1'b1;
            oe_q         <= 1'b0;
            be_q         <= 2'b11;
            addr_q       <= '0;
            dout_q       <= '0;
            disp_ack_q   <= 1'b0;
            mpu_ack_q    <= 1'b0;
            disp_valid_q <= 1'b0;
            mpu_rvalid_q <= 1'b0;
            disp_data_q  <= '0;
            mpu_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            en_q         <= en_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            oe_q         <= oe_d;
            be_q         <= be_d;
            addr_q       <= addr_d;
            dout_q       <= dout_d;
            disp_ack_q   <= disp_ack_d;
            mpu_ack_q    <= mpu_ack_d;
            disp_valid_q <= disp_valid_d;
            mpu_rvalid_q <= mpu_rvalid_d;
            disp_data_q  <= disp_data_d;
            mpu_rdata_q  <= mpu_rdata_d;
        end
    end

    assign _vram_en   = en_q;
    assign _vram_rd   = rd_q;
    assign _vram_wr   = wr_q;
    assign _vram_be   = be_q;
    assign vram_oe    = oe_q;
    assign vram_addr  = addr_q;
    assign vram_dout  = dout_q;
    assign disp_ack   = disp_ack_q;
    assign mpu_ack    = mpu_ack_q;
    assign disp_valid = disp_valid_q;
    assign mpu_rvalid = mpu_rvalid_q;
    assign disp_data  = disp_data_q;
    assign mpu_rdata  = mpu_rdata_q;

`ifndef SYNTHESIS
    // A request not granted at an edge must still be present at the next one.
    a_disp_hold: assert property (@(posedge clk) disable iff (!_reset)
                                  (disp_req && !disp_ack_d) |=> disp_req);
    a_mpu_hold:  assert property (@(posedge clk) disable iff (!_reset)
                                  (mpu_req && !mpu_ack_d) |=> mpu_req);
`endif

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vram_arbiter
//  Purpose  : Directed bench for vram_arbiter with an access-level model of
//             the arbitration rules and a per-cycle output compare.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vram_arbiter;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        _reset = 1'b0;
    logic        disp_req = 1'b0;
    logic [15:0] disp_addr = 16'h0;
    logic        disp_ack, disp_valid;
    logic [15:0] disp_data;
    logic        mpu_req = 1'b0, mpu_wr = 1'b0;
    logic [1:0]  _mpu_be = 2'b00;
    logic [15:0] mpu_addr = 16'h0, mpu_wdata = 16'h0;
    logic        mpu_ack, mpu_rvalid;
    logic [15:0] mpu_rdata;
    logic        _vram_en, _vram_rd, _vram_wr, vram_oe;
    logic [1:0]  _vram_be;
    logic [15:0] vram_addr, vram_dout, vram_din;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MPU_MAX_WAIT(MAXW)) dut (
        .clk(clk), ._reset(_reset),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack),
        .disp_data(disp_data), .disp_valid(disp_valid),
        .mpu_req(mpu_req), .mpu_wr(mpu_wr), ._mpu_be(_mpu_be),
        .mpu_addr(mpu_addr), .mpu_wdata(mpu_wdata), .mpu_ack(mpu_ack),
        .mpu_rdata(mpu_rdata), .mpu_rvalid(mpu_rvalid),
        ._vram_en(_vram_en), ._vram_rd(_vram_rd), ._vram_wr(_vram_wr),
        ._vram_be(_vram_be), .vram_addr(vram_addr), .vram_dout(vram_dout),
        .vram_oe(vram_oe), .vram_din(vram_din)
    );

    // Memory contents seen by reads: one fixed word, otherwise address-derived.
    function automatic logic [15:0] din_of(input logic [15:0] a);
        if (a == 16'h0010) return 16'hA5A5;
        return {a[7:0], ~a[7:0]};
    endfunction

    assign vram_din = din_of(vram_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- access-level model ----------------
    typedef enum int {K_NONE, K_DRD, K_MRD, K_MWR, K_TURN} kind_e;
    kind_e       m_cur, m_prev;
    logic [15:0] m_addr;
    int          m_wait;
    logic        e_en, e_rd, e_wr, e_oe, e_dack, e_mack, e_dval, e_mval;
    logic [1:0]  e_be;
    logic [15:0] e_addr, e_dout, e_ddata, e_mdata;
    bit          chk_addr, chk_dout;

    always @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            m_cur = K_NONE; m_wait = 0; m_addr = 16'h0;
            e_dval = 1'b0; e_mval = 1'b0; e_ddata = 16'h0; e_mdata = 16'h0;
            e_en = 1'b1; e_rd = 1'b1; e_wr = 1'b1; e_oe = 1'b0; e_be = 2'b11;
            e_dack = 1'b0; e_mack = 1'b0;
            e_addr = 16'h0; e_dout = 16'h0; chk_addr = 1'b1; chk_dout = 1'b1;
        end else begin
            m_prev = m_cur;
            e_dval = (m_prev == K_DRD);
            e_mval = (m_prev == K_MRD);
            if (e_dval) e_ddata = din_of(m_addr);
            if (e_mval) e_mdata = din_of(m_addr);
            if (m_prev == K_TURN)
                m_cur = K_MWR;
            else if (mpu_req && (m_wait >= MAXW || !disp_req))
                m_cur = !mpu_wr ? K_MRD :
                        ((m_prev == K_DRD || m_prev == K_MRD) ? K_TURN : K_MWR);
            else if (disp_req)
                m_cur = K_DRD;
            else
                m_cur = K_NONE;
            if (m_cur == K_DRD && mpu_req) m_wait = (m_wait + 1 > MAXW) ? MAXW : m_wait + 1;
            else m_wait = 0;
            m_addr   = (m_cur == K_DRD) ? disp_addr : mpu_addr;
            e_en     = !(m_cur == K_DRD || m_cur == K_MRD || m_cur == K_MWR);
            e_rd     = !(m_cur == K_DRD || m_cur == K_MRD);
            e_wr     = !(m_cur == K_MWR);
            e_oe     = (m_cur == K_MWR);
            e_dack   = (m_cur == K_DRD);
            e_mack   = (m_cur == K_MRD || m_cur == K_MWR);
            e_be     = (m_cur == K_DRD) ? 2'b00 :
                       ((m_cur == K_MRD || m_cur == K_MWR) ? _mpu_be : 2'b11);
            e_addr   = m_addr;
            e_dout   = mpu_wdata;
            chk_addr = !e_en;
            chk_dout = (m_cur == K_MWR);
        end
    end

    // Per-cycle compare on the falling edge, away from the active edge.
    always @(negedge clk) begin
        check("vram_en",    32'(_vram_en),   32'(e_en));
        check("vram_rd",    32'(_vram_rd),   32'(e_rd));
        check("vram_wr",    32'(_vram_wr),   32'(e_wr));
        check("vram_oe",    32'(vram_oe),    32'(e_oe));
        check("vram_be",    32'(_vram_be),   32'(e_be));
        check("disp_ack",   32'(disp_ack),   32'(e_dack));
        check("mpu_ack",    32'(mpu_ack),    32'(e_mack));
        check("disp_valid", 32'(disp_valid), 32'(e_dval));
        check("mpu_rvalid", 32'(mpu_rvalid), 32'(e_mval));
        check("disp_data",  32'(disp_data),  32'(e_ddata));
        check("mpu_rdata",  32'(mpu_rdata),  32'(e_mdata));
        if (chk_addr) check("vram_addr", 32'(vram_addr), 32'(e_addr));
        if (chk_dout) check("vram_dout", 32'(vram_dout), 32'(e_dout));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an MPU request and return in its ack cycle (request still high).
    task automatic mpu_start(input logic wr, input logic [15:0] a,
                             input logic [1:0] be, input logic [15:0] wd);
        bit got;
        got = 1'b0;
        mpu_req = 1'b1; mpu_wr = wr; mpu_addr = a; _mpu_be = be; mpu_wdata = wd;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (mpu_ack) got = 1'b1;
        end
        if (!got) check("mpu_ack_timeout", 32'd0, 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int acks, first_ack, last_ack, run, mruns;
        // Reset state
        repeat (2) tick();
        check("rst_en",    32'(_vram_en),   32'h1);
        check("rst_rdwr",  32'({_vram_rd, _vram_wr}), 32'h3);
        check("rst_be",    32'(_vram_be),   32'h3);
        check("rst_oe",    32'(vram_oe),    32'h0);
        check("rst_addr",  32'(vram_addr),  32'h0);
        check("rst_dout",  32'(vram_dout),  32'h0);
        check("rst_acks",  32'({disp_ack, disp_valid, mpu_ack, mpu_rvalid}), 32'h0);
        #1 _reset = 1'b1;
        repeat (2) tick();

        // Single MPU write
        mpu_start(1'b1, 16'h1234, 2'b00, 16'hBEEF);
        check("wr_strobe", 32'(_vram_wr),  32'h0);
        check("wr_oe",     32'(vram_oe),   32'h1);
        check("wr_addr",   32'(vram_addr), 32'h1234);
        check("wr_dout",   32'(vram_dout), 32'hBEEF);
        mpu_req = 1'b0;
        tick();
        check("wr_no_rvalid", 32'(mpu_rvalid), 32'h0);
        check("wr_ack_pulse", 32'(mpu_ack),    32'h0);

        // MPU read with high byte disabled
        mpu_start(1'b0, 16'h0010, 2'b10, 16'h0000);
        check("rd_be",     32'(_vram_be), 32'h2);
        check("rd_strobe", 32'(_vram_rd), 32'h0);
        mpu_req = 1'b0;
        tick();
        check("rd_rvalid", 32'(mpu_rvalid), 32'h1);
        check("rd_rdata",  32'(mpu_rdata),  32'hA5A5);

        // Write with no bytes enabled still executes
        mpu_start(1'b1, 16'h0055, 2'b11, 16'h1111);
        check("be11_wr", 32'({_vram_wr, _vram_be}), 32'h3);
        mpu_req = 1'b0;
        tick();

        // Display burst 0..7
        acks = 0; first_ack = -1; last_ack = -1;
        disp_req = 1'b1; disp_addr = 16'h0000;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (disp_ack) begin
                if (first_ack < 0) first_ack = i;
                last_ack = i;
                acks++;
                if (acks == 8) disp_req = 1'b0;
                else disp_addr = 16'(acks);
            end
        end
        check("burst_acks",   32'(acks), 32'd8);
        check("burst_consec", 32'(last_ack - first_ack), 32'd7);
        check("burst_last",   32'(disp_data), 32'h07F8);

        // Starvation bound: continuous display with MPU read pending
        run = 0; mruns = 0;
        disp_req = 1'b1; disp_addr = 16'h0100;
        mpu_req = 1'b1; mpu_wr = 1'b0; mpu_addr = 16'h0200; _mpu_be = 2'b00;
        for (int i = 0; i < 20 && mruns < 2; i++) begin
            tick();
            if (disp_ack) run++;
            if (mpu_ack) begin
                mruns++;
                check("starve_run", 32'(run), 32'd4);
                run = 0;
            end
        end
        check("starve_mpu_grants", 32'(mruns), 32'd2);
        mpu_req = 1'b0;
        begin : drain
            bit got;
            got = 1'b0;
            for (int i = 0; i < 5 && !got; i++) begin
                tick();
                if (disp_ack) got = 1'b1;
            end
            if (!got) check("drain_timeout", 32'd0, 32'd1);
            disp_req = 1'b0;
        end
        tick();

        // Display read then MPU write: RD, TURN, WR, then read with no gap
        disp_req = 1'b1; disp_addr = 16'h0030;
        mpu_req = 1'b1; mpu_wr = 1'b1; mpu_addr = 16'h0031; mpu_wdata = 16'hCAFE; _mpu_be = 2'b01;
        tick();
        check("turn_rd_ack", 32'({disp_ack, _vram_rd}), 32'h2);
        disp_req = 1'b0;
        tick();
        check("turn_strobes", 32'({_vram_en, _vram_rd, _vram_wr, vram_oe}), 32'hE);
        check("turn_noack",   32'({mpu_ack, disp_ack}), 32'h0);
        disp_req = 1'b1; disp_addr = 16'h0040;
        tick();
        check("turn_wr", 32'({mpu_ack, _vram_wr, vram_oe, disp_ack}), 32'hA);
        check("turn_wr_data", 32'(vram_dout), 32'hCAFE);
        mpu_req = 1'b0;
        tick();
        check("wr_to_rd", 32'({disp_ack, _vram_rd, vram_oe}), 32'h4);
        check("wr_to_rd_addr", 32'(vram_addr), 32'h0040);
        disp_req = 1'b0;
        repeat (2) tick();

        // Reset in the middle of an MPU read access
        mpu_start(1'b0, 16'h0020, 2'b00, 16'h0000);
        mpu_req = 1'b0;
        #2 _reset = 1'b0;
        #1;
        check("arst_strobes", 32'({_vram_en, _vram_rd, _vram_wr, vram_oe}), 32'hE);
        check("arst_ack",     32'(mpu_ack), 32'h0);
        @(posedge clk); @(posedge clk);
        #2 _reset = 1'b1;
        tick();
        check("arst_no_rvalid1", 32'(mpu_rvalid), 32'h0);
        tick();
        check("arst_no_rvalid2", 32'(mpu_rvalid), 32'h0);
        mpu_start(1'b0, 16'h0010, 2'b00, 16'h0000);
        mpu_req = 1'b0;
        tick();
        check("post_rst_read", 32'({mpu_rvalid, mpu_rdata}), 32'h1A5A5);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
